// File: rtl/bp_cce_hybrid_pending_write_arb.sv
// ---------------------------------------------------------------------------
// bp_cce_hybrid_pending_write_arb
//
// Purpose:
//   Round-robin arbiter that merges pending-bit write requests from
//   num_req_p requesters into a single pending-bit write port. The selected
//   request is captured in a one-entry output register. The register can
//   reload in the same cycle its current write is accepted, so the port
//   sustains one write per cycle.
//
// Ports:
//   clk_i, reset_i                  clock, asynchronous active-high reset
//   req_v_i / req_yumi_o            per-requester valid / accept
//   req_addr_i                      packed addresses, requester k in slice k
//   req_addr_bypass_hash_i          per-requester hash bypass
//   req_up_i/req_down_i/req_clear_i per-requester operation (forwarded as-is)
//   pending_w_v_o / pending_w_yumi_i  output write valid / accept
//   pending_w_addr_o, pending_w_addr_bypass_hash_o,
//   pending_up_o, pending_down_o, pending_clear_o   held write fields
//   grant_id_o                      requester index of the held write
//   busy_o                          output register holds a write
//   wd_error_o                      sticky stall watchdog error
//
// Configuration:
//   BP_CCE_PENDING_WRITE_ARB_WATCHDOG_EN  when defined, counts consecutive
//   stalled cycles. wd_error_o latches once the count reaches wd_cycles_p.
//   When undefined, there is no counter and wd_error_o is tied to 0.
// ---------------------------------------------------------------------------
module bp_cce_hybrid_pending_write_arb #(
    parameter int paddr_width_p = 40,
    parameter int num_req_p     = 3,
    parameter int wd_cycles_p   = 1024
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [num_req_p-1:0]               req_v_i,
    output logic [num_req_p-1:0]               req_yumi_o,
    input  logic [num_req_p*paddr_width_p-1:0] req_addr_i,
    input  logic [num_req_p-1:0]               req_addr_bypass_hash_i,
    input  logic [num_req_p-1:0]               req_up_i,
    input  logic [num_req_p-1:0]               req_down_i,
    input  logic [num_req_p-1:0]               req_clear_i,
    output logic                               pending_w_v_o,
    input  logic                               pending_w_yumi_i,
    output logic [paddr_width_p-1:0]           pending_w_addr_o,
    output logic                               pending_w_addr_bypass_hash_o,
    output logic                               pending_up_o,
    output logic                               pending_down_o,
    output logic                               pending_clear_o,
    output logic [$clog2(num_req_p)-1:0]       grant_id_o,
    output logic                               busy_o,
    output logic                               wd_error_o
);

    localparam int id_width_lp = $clog2(num_req_p);
    localparam logic [id_width_lp-1:0] last_reset_lp = id_width_lp'(num_req_p - 1);

    typedef enum logic {e_empty, e_full} state_e;

    state_e                   state_q, state_d;
    logic [id_width_lp-1:0]   last_q, last_d;
    logic [paddr_width_p-1:0] addr_q, addr_d;
    logic                     bypass_q, bypass_d;
    logic                     up_q, up_d;
    logic                     down_q, down_d;
    logic                     clear_q, clear_d;
    logic [id_width_lp-1:0]   id_q, id_d;

    logic                     load;
    logic                     win_v;
    logic [id_width_lp-1:0]   win_id;
    logic [id_width_lp-1:0]   cand_id;
    int                       cand;
    logic [num_req_p-1:0]     yumi;

    // Unpack the address bus so the winner can be selected by index.
    logic [paddr_width_p-1:0] addr_a [num_req_p];
    for (genvar k = 0; k < num_req_p; k++) begin : g_unpack
        assign addr_a[k] = req_addr_i[k*paddr_width_p +: paddr_width_p];
    end

    // The register can accept a new write when it is empty or when its
    // current write is being taken this cycle. Reset suppresses any grant.
    assign load = ((state_q == e_empty) | pending_w_yumi_i) & ~reset_i;

    // Round-robin search. It starts one past the last winner and wraps,
    // so the last winner is checked last. This lets a lone requester win
    // every cycle.
    always_comb begin
        win_v   = 1'b0;
        win_id  = '0;
        cand    = 0;
        cand_id = '0;
        for (int i = 1; i <= num_req_p; i++) begin
            cand    = (int'(last_q) + i) % num_req_p;
            cand_id = id_width_lp'(cand);
            if (!win_v && req_v_i[cand_id]) begin
                win_v  = 1'b1;
                win_id = cand_id;
            end
        end
    end

    always_comb begin
        yumi = '0;
        if (load && win_v) begin
            yumi[win_id] = 1'b1;
        end
    end

    assign req_yumi_o = yumi;

    // Next-state and output-register capture
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        addr_d   = addr_q;
        bypass_d = bypass_q;
        up_d     = up_q;
        down_d   = down_q;
        clear_d  = clear_q;
        id_d     = id_q;
        if (load) begin
            if (win_v) begin
                state_d  = e_full;
                last_d   = win_id;
                addr_d   = addr_a[win_id];
                bypass_d = req_addr_bypass_hash_i[win_id];
                up_d     = req_up_i[win_id];
                down_d   = req_down_i[win_id];
                clear_d  = req_clear_i[win_id];
                id_d     = win_id;
            end else begin
                state_d  = e_empty;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= e_empty;
            last_q   <= last_reset_lp;
            addr_q   <= '0;
            bypass_q <= 1'b0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            clear_q  <= 1'b0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            bypass_q <= bypass_d;
            up_q     <= up_d;
            down_q   <= down_d;
            clear_q  <= clear_d;
            id_q     <= id_d;
        end
    end

    assign pending_w_v_o                = (state_q == e_full);
    assign busy_o                       = (state_q == e_full);
    assign pending_w_addr_o             = addr_q;
    assign pending_w_addr_bypass_hash_o = bypass_q;
    assign pending_up_o                 = up_q;
    assign pending_down_o               = down_q;
    assign pending_clear_o              = clear_q;
    assign grant_id_o                   = id_q;

`ifdef BP_CCE_PENDING_WRITE_ARB_WATCHDOG_EN
    localparam int wd_width_lp = $clog2(wd_cycles_p + 1);
    localparam logic [wd_width_lp-1:0] wd_max_lp = wd_width_lp'(wd_cycles_p);

    logic [wd_width_lp-1:0] wd_cnt_q, wd_cnt_d;
    logic                   wd_err_q, wd_err_d;

    // Count consecutive stalled cycles. The count saturates so it cannot
    // wrap back below the threshold.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if ((state_q == e_empty) || pending_w_yumi_i) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q != wd_max_lp) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
        wd_err_d = wd_err_q | (wd_cnt_d == wd_max_lp);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            wd_err_q <= wd_err_d;
        end
    end

    assign wd_error_o = wd_err_q;
`else
    assign wd_error_o = 1'b0;
`endif

`ifndef SYNTHESIS
    // An accepted request must carry at most one of up/down/clear.
    always @(posedge clk_i) begin
        if (load && win_v) begin
            assert ($countones({req_up_i[win_id], req_down_i[win_id],
                                req_clear_i[win_id]}) <= 1);
        end
    end
`endif

endmodule

// File: tb/tb_bp_cce_hybrid_pending_write_arb.sv
// ---------------------------------------------------------------------------
// tb_bp_cce_hybrid_pending_write_arb
//
// Purpose:
//   Self-checking bench for bp_cce_hybrid_pending_write_arb. The driver
//   applies stimulus. After each stimulus it pushes the expected response
//   for that cycle into a scoreboard queue. That response comes from a
//   behavioural model: a write queue holding at most one entry, plus a
//   rotating priority index. A separate monitor pops one entry per cycle
//   and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_bp_cce_hybrid_pending_write_arb;

    localparam int AW = 40;
    localparam int N  = 3;
    localparam int WD = 8;
    localparam int IW = $clog2(N);
`ifdef BP_CCE_PENDING_WRITE_ARB_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_i = 1'b1;
    logic [N-1:0]    req_v_i = '0;
    logic [N-1:0]    req_yumi_o;
    logic [N*AW-1:0] req_addr_i = '0;
    logic [N-1:0]    req_byp_i = '0;
    logic [N-1:0]    req_up_i = '0;
    logic [N-1:0]    req_down_i = '0;
    logic [N-1:0]    req_clear_i = '0;
    logic            pending_w_v_o;
    logic            pending_w_yumi_i = 1'b0;
    logic [AW-1:0]   pending_w_addr_o;
    logic            pending_w_addr_bypass_hash_o;
    logic            pending_up_o, pending_down_o, pending_clear_o;
    logic [IW-1:0]   grant_id_o;
    logic            busy_o;
    logic            wd_error_o;

    bp_cce_hybrid_pending_write_arb #(
        .paddr_width_p(AW), .num_req_p(N), .wd_cycles_p(WD)
    ) dut (
        .clk_i                       (clk),
        .reset_i                     (reset_i),
        .req_v_i                     (req_v_i),
        .req_yumi_o                  (req_yumi_o),
        .req_addr_i                  (req_addr_i),
        .req_addr_bypass_hash_i      (req_byp_i),
        .req_up_i                    (req_up_i),
        .req_down_i                  (req_down_i),
        .req_clear_i                 (req_clear_i),
        .pending_w_v_o               (pending_w_v_o),
        .pending_w_yumi_i            (pending_w_yumi_i),
        .pending_w_addr_o            (pending_w_addr_o),
        .pending_w_addr_bypass_hash_o(pending_w_addr_bypass_hash_o),
        .pending_up_o                (pending_up_o),
        .pending_down_o              (pending_down_o),
        .pending_clear_o             (pending_clear_o),
        .grant_id_o                  (grant_id_o),
        .busy_o                      (busy_o),
        .wd_error_o                  (wd_error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          byp, up, dn, clr;
        int            id;
    } wr_t;

    typedef struct {
        logic         v;
        wr_t          w;
        logic [N-1:0] yumi;
        logic         wd;
    } rec_t;

    rec_t sb[$];
    wr_t  held[$];
    int   last = N - 1;
    int   stall = 0;
    logic wd_err = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    logic            nx_rst = 1'b1;
    logic [N-1:0]    nx_v = '0, nx_byp = '0, nx_up = '0, nx_dn = '0, nx_clr = '0;
    logic [N*AW-1:0] nx_addr = '0;
    logic            nx_yumi = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic wr_t zero_wr();
        wr_t z;
        z.addr = '0; z.byp = 1'b0; z.up = 1'b0; z.dn = 1'b0; z.clr = 1'b0; z.id = 0;
        return z;
    endfunction

    task automatic model_reset();
        held.delete();
        last   = N - 1;
        stall  = 0;
        wd_err = 1'b0;
    endtask

    task automatic push_reset_rec();
        rec_t r;
        r.v = 1'b0; r.w = zero_wr(); r.yumi = '0; r.wd = 1'b0;
        sb.push_back(r);
    endtask

    task automatic rand_fields();
        logic [AW-1:0] a;
        int op;
        for (int k = 0; k < N; k++) begin
            a  = AW'({$urandom, $urandom});
            op = $urandom_range(0, 3);
            nx_addr[k*AW +: AW] = a;
            nx_byp[k] = 1'($urandom);
            nx_up[k]  = (op == 1);
            nx_dn[k]  = (op == 2);
            nx_clr[k] = (op == 3);
        end
    endtask

    // Apply one cycle of stimulus, record the expected response, advance model
    task automatic step();
        rec_t r;
        wr_t  g;
        bit   load, gv;
        int   win;
        @(posedge clk);
        #2;
        reset_i = nx_rst;   req_v_i = nx_v;      req_addr_i = nx_addr;
        req_byp_i = nx_byp; req_up_i = nx_up;    req_down_i = nx_dn;
        req_clear_i = nx_clr; pending_w_yumi_i = nx_yumi;
        if (nx_rst) begin
            model_reset();
            push_reset_rec();
            return;
        end
        r.v    = (held.size() != 0);
        r.w    = r.v ? held[0] : zero_wr();
        r.wd   = WD_EN ? wd_err : 1'b0;
        r.yumi = '0;
        load   = !r.v || nx_yumi;
        gv     = 1'b0;
        win    = 0;
        g      = zero_wr();
        if (load) begin
            for (int k = 1; k <= N; k++) begin
                int c = (last + k) % N;
                if (!gv && nx_v[c]) begin
                    gv  = 1'b1;
                    win = c;
                end
            end
        end
        if (gv) begin
            r.yumi[win] = 1'b1;
            g.addr = nx_addr[win*AW +: AW];
            g.byp  = nx_byp[win];
            g.up   = nx_up[win];
            g.dn   = nx_dn[win];
            g.clr  = nx_clr[win];
            g.id   = win;
            last   = win;
        end
        sb.push_back(r);
        if (r.v && !nx_yumi) begin
            if (stall < WD) stall++;
        end else begin
            stall = 0;
        end
        if (stall == WD) wd_err = 1'b1;
        if (r.v && nx_yumi) void'(held.pop_front());
        if (gv) held.push_back(g);
    endtask

    // Assert reset between clock edges while a write is held
    task automatic mid_reset();
        @(posedge clk);
        #2;
        chk("busy_before_reset", 64'(busy_o), 64'(held.size() != 0));
        reset_i = 1'b1;
        #1;
        chk("rst_v",     64'(pending_w_v_o), 64'(0));
        chk("rst_busy",  64'(busy_o), 64'(0));
        chk("rst_yumi",  64'(req_yumi_o), 64'(0));
        chk("rst_addr",  64'(pending_w_addr_o), 64'(0));
        chk("rst_ops",   64'({pending_w_addr_bypass_hash_o, pending_up_o,
                              pending_down_o, pending_clear_o}), 64'(0));
        chk("rst_grant", 64'(grant_id_o), 64'(0));
        chk("rst_wd",    64'(wd_error_o), 64'(0));
        model_reset();
        push_reset_rec();
    endtask

    // Monitor: one scoreboard entry per cycle, sampled late in the cycle
    rec_t mr;
    initial begin
        forever begin
            @(posedge clk);
            #8;
            if (sb.size() != 0) begin
                mr = sb.pop_front();
                chk("req_yumi", 64'(req_yumi_o), 64'(mr.yumi));
                chk("w_v",      64'(pending_w_v_o), 64'(mr.v));
                chk("busy",     64'(busy_o), 64'(mr.v));
                chk("wd_error", 64'(wd_error_o), 64'(mr.wd));
                if (mr.v) begin
                    chk("w_addr",   64'(pending_w_addr_o), 64'(mr.w.addr));
                    chk("w_bypass", 64'(pending_w_addr_bypass_hash_o), 64'(mr.w.byp));
                    chk("w_ops",    64'({pending_up_o, pending_down_o, pending_clear_o}),
                                    64'({mr.w.up, mr.w.dn, mr.w.clr}));
                    chk("grant_id", 64'(grant_id_o), 64'(mr.w.id));
                end
            end
        end
    end

    initial begin
        nx_rst = 1'b1;
        repeat (2) step();
        nx_rst = 1'b0;

        // All requesters valid, port always accepting: 0,1,2,0,1,2
        nx_v = 3'b111; nx_yumi = 1'b1;
        repeat (6) begin rand_fields(); step(); end

        // Single request held under stall, then released
        rand_fields();
        nx_v = 3'b010; nx_addr[AW +: AW] = 40'h1000;
        nx_up = 3'b010; nx_dn = '0; nx_clr = '0; nx_yumi = 1'b0;
        repeat (6) step();
        nx_yumi = 1'b1; step();
        nx_v = '0; step();

        // Back-to-back: requester 2 held, yumi arrives with requester 0 valid
        rand_fields();
        nx_v = 3'b100; nx_yumi = 1'b0;
        repeat (2) step();
        nx_v = 3'b001; nx_yumi = 1'b1; rand_fields(); step();
        nx_v = '0; repeat (2) step();

        // Long stall for the watchdog, then accept; error remains sticky
        nx_v = 3'b001; nx_yumi = 1'b0; rand_fields(); step();
        nx_v = '0; repeat (10) step();
        nx_yumi = 1'b1; repeat (3) step();

        // Lone requester wins every cycle
        nx_v = 3'b100; nx_yumi = 1'b1;
        repeat (4) begin rand_fields(); step(); end
        nx_v = '0; step();

        // Asynchronous reset during a hold, then requester 0 wins first
        nx_v = 3'b010; nx_yumi = 1'b0; rand_fields();
        repeat (2) step();
        mid_reset();
        nx_rst = 1'b1; step();
        nx_rst = 1'b0; nx_v = 3'b111; nx_yumi = 1'b1;
        repeat (3) begin rand_fields(); step(); end

        // Randomized traffic with random stalls and dropped requests
        repeat (400) begin
            nx_v    = N'($urandom);
            nx_yumi = ($urandom_range(0, 3) != 0);
            rand_fields();
            step();
        end

        nx_v = '0; nx_yumi = 1'b1;
        repeat (3) step();
        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
